booth_mac_seq: RTL and testbench
================================

Name: booth_mac_seq

Overview:
- Parameterised, multi-cycle radix-4 Booth multiply/multiply-accumulate unit for the dsp subsystem.
- Retires D Booth digits per cycle.
- Supports full-width signed/unsigned multiply, dual-lane half-width SIMD multiply, and a signed accumulate mode with an internal 2W-bit accumulator.
- Uses valid/ready request and response handshakes so it can sit behind a command queue.

Parameters:
W, 32, operand width; even, >= 8
D, 2, Booth digits retired per cycle; >= 1
(derived) N = ceil((W/2+1)/D), BUSY cycle count; 9 at defaults

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_command  input  3  operation code
req_in_1  input  W  multiplicand / lane-packed operand
req_in_2  input  W  multiplier / lane-packed operand
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_result  output  2W  result

Behaviour:
- Reset: `reset`=0 at a clk edge forces IDLE, req_ready=0 during reset, resp_valid=0, resp_result=0, accumulator=0, digit counter=0. It takes effect from any state, including mid-BUSY; any in-flight operation is discarded with no response.
- Commands:
  - 0 MULU: unsigned W x W -> 2W.
  - 1 MUL: signed W x W -> 2W.
  - 2 MULU2: two unsigned lanes; result[W-1:0] = in_1[W/2-1:0]*in_2[W/2-1:0] and result[2W-1:W] = in_1[W-1:W/2]*in_2[W-1:W/2]. Each lane is W bits. There is no cross-lane carry.
  - 3 MUL2: as 2, with both lanes signed.
  - 4 MAC: acc <= acc + sext(signed in_1*in_2), mod 2^2W; result = new acc.
  - 5 CLRACC: result = old acc; acc <= 0.
  - 6, 7: reserved; result = 0; no state change.
- Operands and command are captured into internal registers on acceptance. Inputs may change afterwards.
- Unsigned operands are zero-extended by 2 bits and signed operands sign-extended by 2 bits, giving W/2+1 digits (W/4+1 per lane). Surplus digit slots in the last cycle contribute 0.
- FSM IDLE:
  - req_ready=1.
  - req_valid&&req_ready with command 0-4 -> BUSY, counter=0.
  - Command 5-7 -> DONE directly, result loaded that edge.
- FSM BUSY:
  - req_ready=0.
  - Each cycle adds D Booth partial products (with their negate increments) to the partial-sum register; counter++.
  - When counter==N-1 -> DONE. Final sum and, for MAC, the accumulator update are registered on that edge.
- FSM DONE:
  - resp_valid=1; resp_result held stable.
  - resp_valid&&resp_ready -> IDLE.
- Latency: for a request accepted at edge t, resp_valid rises after edge t+N (commands 0-4) or after edge t (commands 5-7).
- No overlap: there is no new acceptance in the cycle of a response handshake. req_ready rises the cycle after.
- Backpressure: DONE holds indefinitely and resp_result is unchanged while resp_ready=0.
- Extremes:
  - MAC accumulator wraps silently.
  - Signed most-negative x most-negative gives an exact 2W result (no saturation).
  - In SIMD modes, lane sign bits are bit W/2-1 and bit W-1.
- resp_result is registered; there are no combinational paths from inputs to outputs.

Test Plan (W=32, D=2, N=9):
- MULU, in_1=in_2=0xFFFFFFFF, accept edge t -> resp_valid after edge t+9, result 0xFFFFFFFE00000001.
- MUL, 0x80000000*0x80000000 -> 0x4000000000000000. Then 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFFFFFFFFFE.
- MUL2, in_1=0xFFFF7FFF, in_2=0x00027FFF -> 0xFFFFFFFE3FFF0001. MULU2 with same operands -> 0x0001FFFE3FFF0001.
- Accumulate sequence:
  - CLRACC.
  - MAC 3*4 -> 0x000000000000000C.
  - MAC 0xFFFFFFFF*5 -> 0x0000000000000007.
  - CLRACC -> 0x0000000000000007 after 1 cycle.
  - MAC 1*1 -> 0x0000000000000001.
- Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_result constant, req_ready=0 throughout. The next request is accepted only after the handshake.
- Reset: drive `reset`=0 for one edge at counter=4 of a MAC -> IDLE, resp_valid never asserts, acc=0. A following MAC 2*3 returns 6.

Source files
------------

// File: rtl/booth_mac_seq.sv
// Multi-cycle radix-4 Booth multiplier / multiply-accumulate unit retiring D digits per cycle,
// with full-width signed/unsigned, dual-lane half-width SIMD and a 2W-bit signed accumulator.
module booth_mac_seq #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_command,
  input  logic [W-1:0]   req_in_1,
  input  logic [W-1:0]   req_in_2,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [2*W-1:0] resp_result
);

  localparam int H    = W / 2;
  localparam int NDIG = W / 2 + 1;
  localparam int LN   = (H + 3) / 2;
  localparam int N    = (NDIG + D - 1) / D;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int MW   = W + 2;

  localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [2*W-1:0] ZERO_2W  = {(2*W){1'b0}};
  localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]  ZERO_MW  = {MW{1'b0}};

  localparam logic [2:0] CMD_MULU   = 3'd0;
  localparam logic [2:0] CMD_MUL    = 3'd1;
  localparam logic [2:0] CMD_MULU2  = 3'd2;
  localparam logic [2:0] CMD_MUL2   = 3'd3;
  localparam logic [2:0] CMD_MAC    = 3'd4;
  localparam logic [2:0] CMD_CLRACC = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [2*W-1:0] ext_full(input logic [W-1:0] v, input logic sgn);
    return {{W{sgn & v[W-1]}}, v};
  endfunction

  function automatic logic [W-1:0] ext_half(input logic [H-1:0] v, input logic sgn);
    return {{(W-H){sgn & v[H-1]}}, v};
  endfunction

  function automatic logic [MW-1:0] mext_full(input logic [W-1:0] v, input logic sgn);
    return {{2{sgn & v[W-1]}}, v};
  endfunction

  function automatic logic [MW-1:0] mext_half(input logic [H-1:0] v, input logic sgn);
    return {{(MW-H){sgn & v[H-1]}}, v};
  endfunction

  // Booth triplet {b[2j+1], b[2j], b[2j-1]} with an implicit zero below bit 0
  function automatic logic [2:0] booth_code(input logic [MW-1:0] mpl, input int j);
    return 3'({mpl, 1'b0} >> (2 * j));
  endfunction

  function automatic logic [2*W-1:0] booth_pp(input logic [2*W-1:0] m, input logic [2:0] code);
    logic [2*W-1:0] mag;
    logic           neg;
    case (code)
      3'b001, 3'b010: begin mag = m;                   neg = 1'b0; end
      3'b011:         begin mag = {m[2*W-2:0], 1'b0};  neg = 1'b0; end
      3'b100:         begin mag = {m[2*W-2:0], 1'b0};  neg = 1'b1; end
      3'b101, 3'b110: begin mag = m;                   neg = 1'b1; end
      default:        begin mag = ZERO_2W;             neg = 1'b0; end
    endcase
    return neg ? (~mag + ONE_2W) : mag;
  endfunction

  function automatic logic [W-1:0] booth_pp_w(input logic [W-1:0] m, input logic [2:0] code);
    logic [W-1:0] mag;
    logic         neg;
    case (code)
      3'b001, 3'b010: begin mag = m;                 neg = 1'b0; end
      3'b011:         begin mag = {m[W-2:0], 1'b0};  neg = 1'b0; end
      3'b100:         begin mag = {m[W-2:0], 1'b0};  neg = 1'b1; end
      3'b101, 3'b110: begin mag = m;                 neg = 1'b1; end
      default:        begin mag = ZERO_W;            neg = 1'b0; end
    endcase
    return neg ? (~mag + ONE_W) : mag;
  endfunction

  state_t         state_r;
  state_t         state_next_s;
  logic           accept_s;
  logic           ready_r;
  logic           valid_r;
  logic [2*W-1:0] res_r;
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] psum_r;
  logic [2*W-1:0] psum_next_s;
  logic [2*W-1:0] mac_sum_s;
  logic [CW-1:0]  cnt_r;
  logic           simd_r;
  logic           mac_r;
  logic [2*W-1:0] mc0_r;
  logic [W-1:0]   mc1_r;
  logic [MW-1:0]  mpl0_r;
  logic [MW-1:0]  mpl1_r;
  logic           sgn_s;
  logic           is_simd_s;
  int             dig_idx_s;
  logic [2:0]     code0_s;
  logic [2:0]     code1_s;
  logic [2*W-1:0] add_full_s;
  logic [W-1:0]   add_lo_s;
  logic [W-1:0]   add_hi_s;
  logic [2*W-1:0] sh_full_s;
  logic [W-1:0]   sh_lo_s;
  logic [W-1:0]   sh_hi_s;

  assign sgn_s     = (req_command == CMD_MUL) || (req_command == CMD_MUL2) || (req_command == CMD_MAC);
  assign is_simd_s = (req_command == CMD_MULU2) || (req_command == CMD_MUL2);
  assign mac_sum_s = acc_r + psum_next_s;

  assign req_ready   = ready_r;
  assign resp_valid  = valid_r;
  assign resp_result = res_r;

  // State register plus registered handshake outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == S_IDLE);
      valid_r <= (state_next_s == S_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid && ready_r) begin
          accept_s     = 1'b1;
          state_next_s = (req_command <= CMD_MAC) ? S_BUSY : S_DONE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_r == LAST_CNT) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (valid_r && resp_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // D partial products per cycle; SIMD lanes add into separate W-bit halves so no carry crosses
  always_comb begin
    dig_idx_s  = 0;
    code0_s    = 3'b000;
    code1_s    = 3'b000;
    add_full_s = ZERO_2W;
    add_lo_s   = ZERO_W;
    add_hi_s   = ZERO_W;
    sh_full_s  = ZERO_2W;
    sh_lo_s    = ZERO_W;
    sh_hi_s    = ZERO_W;
    for (int k = 0; k < D; k++) begin
      dig_idx_s  = int'(cnt_r) * D + k;
      code0_s    = booth_code(mpl0_r, dig_idx_s);
      code1_s    = booth_code(mpl1_r, dig_idx_s);
      sh_full_s  = booth_pp(mc0_r, code0_s) << (2 * dig_idx_s);
      sh_lo_s    = booth_pp_w(mc0_r[W-1:0], code0_s) << (2 * dig_idx_s);
      sh_hi_s    = booth_pp_w(mc1_r, code1_s) << (2 * dig_idx_s);
      add_full_s = add_full_s + ((dig_idx_s < NDIG) ? sh_full_s : ZERO_2W);
      add_lo_s   = add_lo_s + ((dig_idx_s < LN) ? sh_lo_s : ZERO_W);
      add_hi_s   = add_hi_s + ((dig_idx_s < LN) ? sh_hi_s : ZERO_W);
    end
    if (simd_r) begin
      psum_next_s = {psum_r[2*W-1:W] + add_hi_s, psum_r[W-1:0] + add_lo_s};
    end else begin
      psum_next_s = psum_r + add_full_s;
    end
  end

  // Operand capture, iteration, result and accumulator registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_r  <= ZERO_2W;
      acc_r  <= ZERO_2W;
      psum_r <= ZERO_2W;
      cnt_r  <= CNT_ZERO;
      simd_r <= 1'b0;
      mac_r  <= 1'b0;
      mc0_r  <= ZERO_2W;
      mc1_r  <= ZERO_W;
      mpl0_r <= ZERO_MW;
      mpl1_r <= ZERO_MW;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            simd_r <= is_simd_s;
            mac_r  <= (req_command == CMD_MAC);
            psum_r <= ZERO_2W;
            cnt_r  <= CNT_ZERO;
            if (is_simd_s) begin
              mc0_r  <= {ZERO_W, ext_half(req_in_1[H-1:0], sgn_s)};
              mc1_r  <= ext_half(req_in_1[W-1:H], sgn_s);
              mpl0_r <= mext_half(req_in_2[H-1:0], sgn_s);
              mpl1_r <= mext_half(req_in_2[W-1:H], sgn_s);
            end else begin
              mc0_r  <= ext_full(req_in_1, sgn_s);
              mc1_r  <= ZERO_W;
              mpl0_r <= mext_full(req_in_2, sgn_s);
              mpl1_r <= ZERO_MW;
            end
            case (req_command)
              CMD_MULU, CMD_MUL, CMD_MULU2, CMD_MUL2, CMD_MAC: res_r <= res_r;
              CMD_CLRACC: begin
                res_r <= acc_r;
                acc_r <= ZERO_2W;
              end
              default: res_r <= ZERO_2W;
            endcase
          end
        end
        S_BUSY: begin
          psum_r <= psum_next_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            res_r <= mac_r ? mac_sum_s : psum_next_s;
            acc_r <= mac_r ? mac_sum_s : acc_r;
          end
        end
        S_DONE: res_r <= res_r;
        default: res_r <= res_r;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Scoreboard bench for booth_mac_seq: stimulus pushes expected results and latencies,
// a negedge monitor checks each response as it is presented.
module tb_booth_mac_seq;

  localparam int W = 32;
  localparam int D = 2;
  localparam int N = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_command;
  logic [W-1:0]   req_in_1;
  logic [W-1:0]   req_in_2;
  logic           resp_valid;
  logic           resp_ready;
  logic [2*W-1:0] resp_result;

  booth_mac_seq #(.W(W), .D(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_command(req_command),
    .req_in_1   (req_in_1),
    .req_in_2   (req_in_2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   last_acc_cyc = 0;
  bit   prev_valid = 1'b0;

  // Monitor: latency on the rising edge of resp_valid, value on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid && !prev_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got result %h with no request outstanding", resp_result);
      end else if (cyc - sb[0].acc_cyc != sb[0].lat) begin
        fails++;
        $display("FAIL %s_latency: got %0d cycles, expected %0d", sb[0].name, cyc - sb[0].acc_cyc, sb[0].lat);
      end
    end
    if (resp_valid && resp_ready && sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (resp_result !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, resp_result, e.exp);
      end
    end
    prev_valid = resp_valid;
  end

  task automatic drive(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid   = 1'b1;
    req_command = cmd;
    req_in_1    = a;
    req_in_2    = b;
  endtask

  task automatic wait_accept(input logic [63:0] exp, input int lat, input string name, input bit track);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s_accept: req_ready stayed %b for %0d cycles, expected 1", name, req_ready, n);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    if (track) begin
      e.exp = exp; e.lat = lat; e.acc_cyc = cyc; e.name = name;
      sb.push_back(e);
    end
    req_valid   = 1'b0;
    req_command = 3'd7;
    req_in_1    = 32'hDEADBEEF;
    req_in_2    = 32'h5A5A5A5A;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [63:0] exp, input int lat, input string name);
    drive(cmd, a, b);
    wait_accept(exp, lat, name, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bp_ok;
    bit quiet;
    int hs_cyc;
    int n;
    reset = 1'b0; req_valid = 1'b0; req_command = 3'd0;
    req_in_1 = 32'h0; req_in_2 = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_result !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: got ready=%b valid=%b result=%h expected 0/0/0", req_ready, resp_valid, resp_result);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, N, "mulu_max");
    issue(3'd1, 32'h80000000, 32'h80000000, 64'h4000000000000000, N, "mul_minmin");
    issue(3'd1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE, N, "mul_neg1x2");
    issue(3'd1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, N, "mul_maxmin");
    issue(3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'h0000000000000006, N, "mul_negneg");
    issue(3'd3, 32'hFFFF7FFF, 32'h00027FFF, 64'hFFFFFFFE3FFF0001, N, "mul2");
    issue(3'd2, 32'hFFFF7FFF, 32'h00027FFF, 64'h0001FFFE3FFF0001, N, "mulu2");
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFE0001FFFE0001, N, "mulu2_max");
    issue(3'd0, 32'h00000000, 32'h12345678, 64'h0000000000000000, N, "mulu_zero");
    issue(3'd6, 32'h00001234, 32'h00005678, 64'h0000000000000000, 0, "rsvd6");

    issue(3'd5, 32'h0, 32'h0, 64'h0000000000000000, 0, "clracc_init");
    issue(3'd4, 32'h00000003, 32'h00000004, 64'h000000000000000C, N, "mac_3x4");
    issue(3'd4, 32'hFFFFFFFF, 32'h00000005, 64'h0000000000000007, N, "mac_m1x5");
    issue(3'd7, 32'h11111111, 32'h22222222, 64'h0000000000000000, 0, "rsvd7");
    issue(3'd5, 32'h0, 32'h0, 64'h0000000000000007, 0, "clracc_7");
    issue(3'd4, 32'h00000001, 32'h00000001, 64'h0000000000000001, N, "mac_1x1");
    drain();

    resp_ready = 1'b0;
    issue(3'd0, 32'h00000010, 32'h00000020, 64'h0000000000000200, N, "bp_mulu");
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    drive(3'd1, 32'h00000002, 32'h00000003);
    bp_ok = (n < 50);
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_result !== 64'h200 || req_ready !== 1'b0 || resp_valid !== 1'b1) bp_ok = 1'b0;
    end
    tests++;
    if (!bp_ok) begin
      fails++;
      $display("FAIL backpressure_hold: got valid=%b ready=%b result=%h expected 1/0/%h", resp_valid, req_ready, resp_result, 64'h200);
    end
    resp_ready = 1'b1;
    hs_cyc = cyc;
    wait_accept(64'h0000000000000006, N, "bp_next_mul", 1'b1);
    tests++;
    if (last_acc_cyc != hs_cyc + 2) begin
      fails++;
      $display("FAIL bp_accept_time: got edge %0d expected edge %0d", last_acc_cyc, hs_cyc + 2);
    end
    drain();

    drive(3'd4, 32'h00000007, 32'h00000007);
    wait_accept(64'h0, N, "rst_mac", 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_result !== 64'h0) begin
      fails++;
      $display("FAIL midbusy_reset: got ready=%b valid=%b result=%h expected 0/0/0", req_ready, resp_valid, resp_result);
    end
    reset = 1'b1;
    quiet = 1'b1;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (resp_valid) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL reset_no_resp: got resp_valid=1 after aborted MAC, expected 0");
    end
    issue(3'd4, 32'h00000002, 32'h00000003, 64'h0000000000000006, N, "mac_after_reset");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
